// File: rtl/keypad_pkg.sv
// Shared keypad constants: key-code values, key count and code width.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package keypad_pkg;

  localparam int NUM_KEYS   = 12;
  localparam int KEY_CODE_W = 4;

  typedef logic [KEY_CODE_W-1:0] key_code_t;
  typedef logic [NUM_KEYS-1:0]   key_mask_t;

  // Code of a key equals its bit index in the scanner level vector.
  localparam key_code_t KEY_0     = 4'd0;
  localparam key_code_t KEY_1     = 4'd1;
  localparam key_code_t KEY_2     = 4'd2;
  localparam key_code_t KEY_3     = 4'd3;
  localparam key_code_t KEY_4     = 4'd4;
  localparam key_code_t KEY_5     = 4'd5;
  localparam key_code_t KEY_6     = 4'd6;
  localparam key_code_t KEY_7     = 4'd7;
  localparam key_code_t KEY_8     = 4'd8;
  localparam key_code_t KEY_9     = 4'd9;
  localparam key_code_t KEY_STAR  = 4'd10;
  localparam key_code_t KEY_SHARP = 4'd11;

endpackage

// File: rtl/keypad_event_encoder_if.sv
// Key-event stream: valid/ready handshake carrying one key code per transfer.
// Latency: n/a (wires only).
// Backpressure: producer holds ev_valid/ev_code until ev_ready is seen high.
interface keypad_event_encoder_if;

  logic                         ev_valid;
  logic [keypad_pkg::KEY_CODE_W-1:0] ev_code;
  logic                         ev_ready;

  modport master (output ev_valid, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_code, output ev_ready);

endinterface

// File: rtl/keypad_debounce.sv
// One-key debouncer: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
// Latency: stable follows raw DEBOUNCE_CYCLES clk after a clean change; rise pulses the cycle before.
// Backpressure: none; free-running per key.
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             flip;

  // The counter is about to reach DEBOUNCE_CYCLES: stable takes raw on this edge.
  assign flip = (raw != stable) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  // Rise is early by one cycle so the press can be marked pending on the same edge stable rises.
  assign rise = flip & raw;

  // Count consecutive disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      stable <= 1'b0;
    end else if (raw == stable) begin
      cnt_q  <= '0;
    end else if (flip) begin
      cnt_q  <= '0;
      stable <= raw;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_event_encoder.sv
// Keypad event encoder: debounce 12 keys, queue each press as a key code (KEYPAD_AUTOREPEAT_EN adds hold-repeat).
// Latency: ev_valid rises 1 clk after the key_down bit when the FIFO is empty.
// Backpressure: FIFO full holds presses in the pending mask; a re-press of a still-pending key sets ovf.
module keypad_event_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_raw,
  keypad_event_encoder_if.master      ev,
  output logic [NUM_KEYS-1:0]         key_down,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keypad_event_encoder: illegal parameter value");
  end

  key_mask_t rise;
  key_mask_t rep_mask;
  key_mask_t pend_q;
  key_mask_t push_mask;
  key_mask_t lost;

  key_code_t mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q, rd_n;
  logic [CNT_W-1:0] count_q, count_n;
  key_code_t        code_q, head_n;

  logic      sel_vld;
  key_code_t sel_code;
  logic      push, pop;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (key_raw[g]),
      .stable (key_down[g]),
      .rise   (rise[g])
    );
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_first_q;
  key_mask_t        kd_prev_q;
  logic             held;
  logic             rep_fire;

  // Exactly one key down and unchanged since the last cycle. The counter only starts one cycle
  // after a key_down change is seen, so the first threshold is one short of REPEAT_DELAY.
  assign held     = (key_down != '0) && ((key_down & (key_down - 1'b1)) == '0) && (key_down == kd_prev_q);
  assign rep_fire = held && ((rep_cnt_q + 1'b1) ==
                    (rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD)));
  assign rep_mask = rep_fire ? key_down : '0;

  // Hold timer: restarts on any key_down change, first interval REPEAT_DELAY then REPEAT_PERIOD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      kd_prev_q   <= '0;
    end else begin
      kd_prev_q <= key_down;
      if (!held) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
      end else if (rep_fire) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b0;
      end else begin
        rep_cnt_q   <= rep_cnt_q + 1'b1;
      end
    end
  end
`else
  assign rep_mask = '0;
`endif

  // Lowest-index pending key wins, so simultaneous presses leave in ascending code order.
  always_comb begin
    sel_vld  = 1'b0;
    sel_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_vld  = 1'b1;
        sel_code = KEY_CODE_W'(i);
      end
    end
  end

  assign pop       = ev.ev_valid & ev.ev_ready;
  assign push      = sel_vld && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
  assign push_mask = push ? (key_mask_t'(1) << sel_code) : '0;
  // Only a real press landing on a still-pending bit is a loss; repeats merge silently.
  assign lost      = rise & pend_q & ~push_mask;

  // Next FIFO state and the head code that ev_code will register.
  always_comb begin
    count_n = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_n    = pop ? rd_q + 1'b1 : rd_q;
    head_n  = '0;
    if (count_n != '0) begin
      // The head is the entry written on this very edge when nothing older remains.
      if (push && (count_q == '0 || (pop && count_q == CNT_W'(1)))) begin
        head_n = sel_code;
      end else begin
        head_n = mem[rd_n];
      end
    end
  end

  // Pending mask, FIFO pointers, registered head code and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      code_q  <= '0;
      ovf     <= 1'b0;
    end else begin
      pend_q  <= (pend_q & ~push_mask) | rise | rep_mask;
      wr_q    <= push ? wr_q + 1'b1 : wr_q;
      rd_q    <= rd_n;
      count_q <= count_n;
      code_q  <= head_n;
      if (lost != '0) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Entry storage carries no reset; only slots covered by count_q are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= sel_code;
    end
  end

  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_code  = code_q;
  assign fifo_count  = count_q;

endmodule
